// File: rtl/shared_reg_bank_arbiter_pkg.sv
// Shared types and default sizing for the shared register bank arbiter.
package shared_reg_bank_arbiter_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } arb_state_e;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_ADDR_W   = 2;
  localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/shared_reg_bank_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr_i, wrapping.
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic [N_REQ-1:0] winner_o,
  output logic [IDX_W-1:0] winner_idx_o,
  output logic             valid_o
);

  always_comb begin
    logic found;
    int   idx;
    found        = 1'b0;
    idx          = 0;
    winner_o     = '0;
    winner_idx_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_i) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        winner_o[idx] = 1'b1;
        winner_idx_o  = IDX_W'(idx);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/shared_reg_bank_arbiter.sv
// Round-robin write arbiter over a small register bank with a hold-time watchdog.
// One requester owns write access at a time; reads are combinational and unarbitrated.
module shared_reg_bank_arbiter
  import shared_reg_bank_arbiter_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        wr_en,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic                    timeout,
  output logic [WIDTH-1:0]        rd_data
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_HOLD);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] g_idx_q, g_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i        (req),
    .rr_ptr_i     (rr_ptr_q),
    .winner_o     (pick_onehot),
    .winner_idx_o (pick_idx),
    .valid_o      (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    g_idx_d    = g_idx_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d    = ST_GRANTED;
          gnt_d      = pick_onehot;
          g_idx_d    = pick_idx;
          hold_cnt_d = '0;
        end
      end
      ST_GRANTED: begin
        hold_cnt_d = hold_cnt_q + CNT_W'(1);
        if (!req[g_idx_q] || hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          state_d    = ST_IDLE;
          gnt_d      = '0;
          hold_cnt_d = '0;
          rr_ptr_d   = (int'(g_idx_q) == N_REQ - 1) ? '0 : g_idx_q + IDX_W'(1);
          // A dropped request wins over the watchdog, so only a still-held request flags timeout
          timeout_d  = req[g_idx_q];
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      g_idx_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      g_idx_q    <= g_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  // Writes follow the registered grant, so the release cycle still commits its write
  logic                   wr_fire;
  logic [ADDR_W-1:0]      wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic [DEPTH*WIDTH-1:0] bank_flat;

  assign wr_fire = busy_q && wr_en[g_idx_q];
  assign wr_addr = addr[int'(g_idx_q)*ADDR_W +: ADDR_W];
  assign wr_data = wdata[int'(g_idx_q)*WIDTH +: WIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [WIDTH-1:0] word_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          word_q <= '0;
        end else if (wr_fire && wr_addr == ADDR_W'(gi)) begin
          word_q <= wr_data;
        end
      end
      assign bank_flat[gi*WIDTH +: WIDTH] = word_q;
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (rd_addr == ADDR_W'(k)) rd_data = bank_flat[k*WIDTH +: WIDTH];
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_shared_reg_bank_arbiter.sv
// Bench for shared_reg_bank_arbiter: directed scenarios plus random traffic against a cycle model.
// A second instance with DEPTH=3 shares the stimulus to exercise out-of-range addresses.
module tb_shared_reg_bank_arbiter;

  localparam int N_REQ    = 4;
  localparam int WIDTH    = 8;
  localparam int ADDR_W   = 2;
  localparam int MAX_HOLD = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        wr_en;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*WIDTH-1:0]  wdata;
  logic [ADDR_W-1:0]       rd_addr;
  logic [N_REQ-1:0]        gnt4, gnt3;
  logic                    busy4, busy3, to4, to3;
  logic [WIDTH-1:0]        rd4, rd3;

  always #5 clk = ~clk;

  shared_reg_bank_arbiter #(.N_REQ(4), .WIDTH(8), .DEPTH(4), .ADDR_W(2), .MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset), .req(req), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rd_addr(rd_addr), .gnt(gnt4), .busy(busy4), .timeout(to4), .rd_data(rd4)
  );

  shared_reg_bank_arbiter #(.N_REQ(4), .WIDTH(8), .DEPTH(3), .ADDR_W(2), .MAX_HOLD(8)) dut3 (
    .clk(clk), .reset(reset), .req(req), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rd_addr(rd_addr), .gnt(gnt3), .busy(busy3), .timeout(to3), .rd_data(rd3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: current owner (-1 = none), cycles held, next-scan start, bank contents
  int         m_owner, m_held, m_rr;
  logic       m_to;
  logic [7:0] m_bank4 [4];
  logic [7:0] m_bank3 [3];

  task automatic model_step(input logic rst_v, input logic [3:0] req_v, input logic [3:0] we_v,
                            input logic [7:0] addr_v, input logic [31:0] wd_v);
    int a;
    logic [7:0] d;
    if (rst_v) begin
      m_owner = -1; m_held = 0; m_rr = 0; m_to = 1'b0;
      for (int i = 0; i < 4; i++) m_bank4[i] = 8'h00;
      for (int i = 0; i < 3; i++) m_bank3[i] = 8'h00;
      return;
    end
    if (m_owner >= 0 && we_v[m_owner]) begin
      a = int'(addr_v[m_owner*ADDR_W +: ADDR_W]);
      d = wd_v[m_owner*WIDTH +: WIDTH];
      if (a < 4) m_bank4[a] = d;
      if (a < 3) m_bank3[a] = d;
    end
    m_to = 1'b0;
    if (m_owner >= 0) begin
      m_held++;
      if (!req_v[m_owner]) begin
        m_rr = (m_owner + 1) % N_REQ; m_owner = -1;
      end else if (m_held == MAX_HOLD) begin
        m_to = 1'b1; m_rr = (m_owner + 1) % N_REQ; m_owner = -1;
      end
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        int i;
        i = (m_rr + k) % N_REQ;
        if (m_owner < 0 && req_v[i]) begin
          m_owner = i; m_held = 0;
        end
      end
    end
  endtask

  // Observation captures and grant logs for directed checks
  logic [3:0] o_gnt, prev_gnt;
  logic       o_busy, o_to;
  logic [7:0] o_rd4, o_rd3;
  int         cyc = 0;
  int         to_count = 0;
  int         g_order[$];
  int         g_start[$];
  logic [3:0] want;
  logic       dropped;

  task automatic do_cycle(input logic rst_v, input logic [3:0] req_v, input logic [3:0] we_v,
                          input logic [7:0] addr_v, input logic [31:0] wd_v, input logic [1:0] ra_v);
    logic [3:0] eg;
    logic [7:0] e3;
    int gi;
    @(negedge clk);
    rd_addr = ra_v;
    #1;
    o_gnt = gnt4; o_busy = busy4; o_to = to4; o_rd4 = rd4; o_rd3 = rd3;
    eg = 4'b0000;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    e3 = 8'h00;
    if (ra_v < 3) e3 = m_bank3[ra_v];
    check_eq("gnt", o_gnt, eg);
    check_eq("busy", o_busy, m_owner >= 0);
    check_eq("timeout", o_to, m_to);
    check_eq("rd_data", o_rd4, m_bank4[ra_v]);
    check_eq("gnt_d3", gnt3, eg);
    check_eq("busy_d3", busy3, m_owner >= 0);
    check_eq("timeout_d3", to3, m_to);
    check_eq("rd_data_d3", o_rd3, e3);
    if (o_gnt != 4'b0000 && prev_gnt == 4'b0000) begin
      gi = 0;
      for (int k = 0; k < 4; k++) if (o_gnt[k]) gi = k;
      g_order.push_back(gi);
      g_start.push_back(cyc);
    end
    if (o_to) to_count++;
    prev_gnt = o_gnt;
    $display("cyc=%0d rst=%b req=%b we=%b gnt=%b busy=%b to=%b rd[%0d]=%h/%h",
             cyc, rst_v, req_v, we_v, o_gnt, o_busy, o_to, ra_v, o_rd4, o_rd3);
    reset = rst_v; req = req_v; wr_en = we_v; addr = addr_v; wdata = wd_v;
    model_step(rst_v, req_v, we_v, addr_v, wd_v);
    cyc++;
  endtask

  task automatic clear_logs();
    g_order.delete();
    g_start.delete();
    to_count = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = '0; wr_en = '0; addr = '0; wdata = '0; rd_addr = '0;
    prev_gnt = 4'b0000; want = 4'b0000; dropped = 1'b0;
    model_step(1'b1, 4'b0, 4'b0, 8'h00, 32'h0);
    repeat (2) @(posedge clk);

    // Reset mid-grant drops the write and clears the bank
    do_cycle(0, 4'b0010, 4'b0000, 8'h00, 32'h0, 2'd2);
    check_eq("rst_gnt", o_gnt, 4'b0000);
    check_eq("rst_busy", o_busy, 1'b0);
    check_eq("rst_timeout", o_to, 1'b0);
    do_cycle(0, 4'b0010, 4'b0010, 8'h08, 32'h0000_5A00, 2'd2);
    check_eq("t1_gnt", o_gnt, 4'b0010);
    do_cycle(0, 4'b0010, 4'b0000, 8'h00, 32'h0, 2'd2);
    check_eq("t1_rd_written", o_rd4, 8'h5A);
    do_cycle(1, 4'b0010, 4'b0010, 8'h08, 32'h0000_7700, 2'd2);
    do_cycle(0, 4'b0000, 4'b0000, 8'h00, 32'h0, 2'd2);
    check_eq("t1_gnt_after_rst", o_gnt, 4'b0000);
    check_eq("t1_busy_after_rst", o_busy, 1'b0);
    check_eq("t1_rd_after_rst", o_rd4, 8'h00);

    // Single requester: one-cycle grant latency, write visible the cycle after its edge
    do_cycle(0, 4'b0100, 4'b0000, 8'h00, 32'h0, 2'd1);
    do_cycle(0, 4'b0100, 4'b0100, 8'h10, 32'h00C3_0000, 2'd1);
    check_eq("t2_gnt", o_gnt, 4'b0100);
    check_eq("t2_rd_before", o_rd4, 8'h00);
    do_cycle(0, 4'b0000, 4'b0000, 8'h00, 32'h0, 2'd1);
    check_eq("t2_rd_after", o_rd4, 8'hC3);
    do_cycle(0, 4'b0000, 4'b0000, 8'h00, 32'h0, 2'd1);

    // Round robin: all request, each owner writes once then drops
    do_cycle(1, 4'b0000, 4'b0000, 8'h00, 32'h0, 2'd0);
    clear_logs();
    for (int c = 0; c < 18; c++) begin
      logic [3:0] rq, we;
      logic [7:0] av;
      logic [31:0] dv;
      rq = 4'b1111; we = 4'b0000; av = 8'h00; dv = 32'h0;
      if (m_owner >= 0) begin
        if (m_held == 0) begin
          we[m_owner] = 1'b1;
          av[m_owner*ADDR_W +: ADDR_W] = 2'(m_owner);
          dv[m_owner*WIDTH +: WIDTH] = 8'h10 + 8'(m_owner);
        end else begin
          rq[m_owner] = 1'b0;
        end
      end
      do_cycle(0, rq, we, av, dv, 2'($urandom_range(0, 3)));
    end
    check_eq("t3_grant_count_ok", g_order.size() >= 5, 1'b1);
    if (g_order.size() >= 5) begin
      check_eq("t3_order0", g_order[0], 0);
      check_eq("t3_order1", g_order[1], 1);
      check_eq("t3_order2", g_order[2], 2);
      check_eq("t3_order3", g_order[3], 3);
      check_eq("t3_order4", g_order[4], 0);
      for (int k = 0; k < 4; k++) check_eq("t3_spacing", g_start[k+1] - g_start[k], 3);
    end

    // Watchdog: sole requester held 20 cycles
    do_cycle(1, 4'b0000, 4'b0000, 8'h00, 32'h0, 2'd0);
    do_cycle(0, 4'b1000, 4'b0000, 8'h00, 32'h0, 2'd0);
    clear_logs();
    for (int c = 0; c < 20; c++) do_cycle(0, 4'b1000, 4'b0000, 8'h00, 32'h0, 2'd0);
    check_eq("t4_timeouts", to_count, 2);
    check_eq("t4_regrants_ok", g_order.size() >= 2, 1'b1);
    if (g_order.size() >= 2) begin
      check_eq("t4_owner_a", g_order[0], 3);
      check_eq("t4_owner_b", g_order[1], 3);
      check_eq("t4_period", g_start[1] - g_start[0], MAX_HOLD + 1);
    end

    // Request drop on the limit cycle releases without a timeout pulse
    do_cycle(1, 4'b0000, 4'b0000, 8'h00, 32'h0, 2'd0);
    clear_logs();
    dropped = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (m_owner == 3 && m_held == MAX_HOLD - 1) dropped = 1'b1;
      do_cycle(0, dropped ? 4'b0000 : 4'b1000, 4'b0000, 8'h00, 32'h0, 2'd0);
    end
    check_eq("t4b_dropped", dropped, 1'b1);
    check_eq("t4b_no_timeout", to_count, 0);
    check_eq("t4b_single_grant", g_order.size(), 1);

    // Non-granted writer is ignored; then out-of-range address on the DEPTH=3 instance
    do_cycle(1, 4'b0000, 4'b0000, 8'h00, 32'h0, 2'd0);
    do_cycle(0, 4'b0001, 4'b0000, 8'h00, 32'h0, 2'd0);
    for (int c = 0; c < 3; c++) do_cycle(0, 4'b0011, 4'b0010, 8'h00, 32'h0000_FF00, 2'd0);
    check_eq("t5_gnt_held", o_gnt, 4'b0001);
    do_cycle(0, 4'b0001, 4'b0001, 8'h03, 32'h0000_00AB, 2'd0);
    check_eq("t5_bank0_unchanged", o_rd4, 8'h00);
    do_cycle(0, 4'b0001, 4'b0000, 8'h00, 32'h0, 2'd3);
    check_eq("t6_rd_d4_addr3", o_rd4, 8'hAB);
    check_eq("t6_rd_d3_addr3", o_rd3, 8'h00);

    // Random traffic with sticky requests so long holds and timeouts occur
    want = 4'b0000;
    for (int c = 0; c < 300; c++) begin
      for (int r = 0; r < 4; r++) if ($urandom_range(0, 7) == 0) want[r] = ~want[r];
      do_cycle($urandom_range(0, 99) == 0, want, 4'($urandom), 8'($urandom), $urandom,
               2'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
